// File: rtl/mp_cache_pkg.sv
// Shared constants, entry layout and address-field helpers for the
// 4-way / 16-set tag lookup stage.
package mp_cache_pkg;

  localparam int WAYS      = 4;
  localparam int SETS      = 16;
  localparam int TAG_W     = 24;
  localparam int IDX_W     = 4;
  localparam int WAY_W     = 2;
  localparam int OFF_W     = 4;
  localparam int ENTRY_W   = TAG_W + 2;
  localparam int VALID_BIT = 25;
  localparam int DIRTY_BIT = 24;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:OFF_W+IDX_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_set(input logic [31:0] addr);
    return addr[OFF_W+IDX_W-1:OFF_W];
  endfunction

endpackage

// File: rtl/mp_cache_plru4.sv
// Per-set tree-PLRU state for a 4-way cache, with victim selection that
// prefers the lowest-index invalid way.
module mp_cache_plru4
  import mp_cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_set,
  input  logic [WAYS-1:0]  way_valid,
  output logic [WAY_W-1:0] victim_way,
  input  logic             touch_a_en,
  input  logic [IDX_W-1:0] touch_a_set,
  input  logic [WAY_W-1:0] touch_a_way,
  input  logic             touch_b_en,
  input  logic [IDX_W-1:0] touch_b_set,
  input  logic [WAY_W-1:0] touch_b_way
);

  logic [2:0] plru_q [SETS];
  logic [2:0] plru_d [SETS];
  logic [2:0] rd_bits;

  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [WAY_W-1:0] way);
    logic [2:0] r;
    r = bits;
    if (way < 2'd2) begin
      r[0] = 1'b1;
      r[1] = (way == 2'd0);
    end else begin
      r[0] = 1'b0;
      r[2] = (way == 2'd2);
    end
    return r;
  endfunction

  // Touch B (the tag update) is applied after touch A so it wins on a shared set.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      plru_d[s] = plru_q[s];
      if (touch_a_en && touch_a_set == IDX_W'(s)) plru_d[s] = plru_touch(plru_d[s], touch_a_way);
      if (touch_b_en && touch_b_set == IDX_W'(s)) plru_d[s] = plru_touch(plru_d[s], touch_b_way);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= plru_d[s];
    end
  end

  always_comb begin
    rd_bits    = plru_q[rd_set];
    victim_way = rd_bits[0] ? (rd_bits[2] ? 2'd3 : 2'd2) : (rd_bits[1] ? 2'd1 : 2'd0);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_way = WAY_W'(w);
    end
  end

endmodule

// File: rtl/mp_cache_tag_lookup.sv
// Tag lookup/compare stage: clears the tag SRAMs after reset, then serves
// lookups and tag updates against four single-port tag SRAMs.
module mp_cache_tag_lookup
  import mp_cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic [WAY_W-1:0]         resp_way,
  output logic [WAY_W-1:0]         resp_victim_way,
  output logic                     resp_victim_valid,
  output logic                     resp_victim_dirty,
  output logic [TAG_W-1:0]         resp_victim_tag,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [WAY_W-1:0]         upd_way,
  input  logic [IDX_W-1:0]         upd_set,
  input  logic [ENTRY_W-1:0]       upd_entry,
  output logic [WAYS-1:0]          sram_csb,
  output logic [WAYS-1:0]          sram_web,
  output logic [WAYS*IDX_W-1:0]    sram_addr,
  output logic [WAYS*ENTRY_W-1:0]  sram_din,
  input  logic [WAYS*ENTRY_W-1:0]  sram_dout
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic             s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [IDX_W-1:0] s1_set_q, s1_set_d;

  logic             free;
  logic             upd_fire;
  logic             req_fire;
  logic             resp_fire;
  logic [WAYS-1:0]  hit_vec;
  logic [WAYS-1:0]  valid_vec;
  tag_entry_t       dout_e [WAYS];
  logic [WAY_W-1:0] victim_way;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign dout_e[gi]    = tag_entry_t'(sram_dout[gi*ENTRY_W +: ENTRY_W]);
      assign valid_vec[gi] = sram_dout[gi*ENTRY_W + VALID_BIT];
      assign hit_vec[gi]   = valid_vec[gi] && (dout_e[gi].tag == s1_tag_q);
    end
  endgenerate

  always_comb begin
    resp_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) resp_way = WAY_W'(w);
    end
  end

  assign resp_valid        = s1_valid_q;
  assign resp_hit          = |hit_vec;
  assign resp_victim_way   = victim_way;
  assign resp_victim_valid = dout_e[victim_way].valid;
  assign resp_victim_dirty = dout_e[victim_way].dirty;
  assign resp_victim_tag   = dout_e[victim_way].tag;

  // SRAM controls are combinational: the macro samples them on the edge itself.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    s1_valid_d = s1_valid_q;
    s1_tag_d   = s1_tag_q;
    s1_set_d   = s1_set_q;
    free       = 1'b0;
    req_ready  = 1'b0;
    upd_ready  = 1'b0;
    upd_fire   = 1'b0;
    req_fire   = 1'b0;
    resp_fire  = 1'b0;
    sram_csb   = '1;
    sram_web   = '1;
    sram_addr  = '0;
    sram_din   = '0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          sram_csb = '0;
          sram_web = '0;
          for (int w = 0; w < WAYS; w++) sram_addr[w*IDX_W +: IDX_W] = init_cnt_q;
          init_cnt_d = init_cnt_q + 4'd1;
          if (init_cnt_q == IDX_W'(SETS - 1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          free      = !s1_valid_q || resp_ready;
          upd_ready = free;
          req_ready = free && !upd_valid;
          upd_fire  = upd_valid && upd_ready;
          req_fire  = req_valid && req_ready;
          resp_fire = s1_valid_q && resp_ready;
          if (upd_fire) begin
            sram_csb[upd_way]                       = 1'b0;
            sram_web[upd_way]                       = 1'b0;
            sram_addr[upd_way*IDX_W +: IDX_W]       = upd_set;
            sram_din[upd_way*ENTRY_W +: ENTRY_W]    = upd_entry;
          end else if (req_fire) begin
            sram_csb = '0;
            for (int w = 0; w < WAYS; w++) sram_addr[w*IDX_W +: IDX_W] = addr_set(req_addr);
          end
          if (req_fire) begin
            s1_valid_d = 1'b1;
            s1_tag_d   = addr_tag(req_addr);
            s1_set_d   = addr_set(req_addr);
          end else if (resp_fire) begin
            s1_valid_d = 1'b0;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_set_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s1_set_q   <= s1_set_d;
    end
  end

  mp_cache_plru4 u_plru (
    .clk         (clk),
    .rst         (rst),
    .rd_set      (s1_set_q),
    .way_valid   (valid_vec),
    .victim_way  (victim_way),
    .touch_a_en  (resp_fire && resp_hit),
    .touch_a_set (s1_set_q),
    .touch_a_way (resp_way),
    .touch_b_en  (upd_fire && upd_entry[VALID_BIT]),
    .touch_b_set (upd_set),
    .touch_b_way (upd_way)
  );

  // A tag may live in at most one way of a set.
  a_onehot_hit: assert property (@(posedge clk) disable iff (rst) s1_valid_q |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_mp_cache_tag_lookup.sv
// Directed bench for mp_cache_tag_lookup with a behavioural model of the
// four tag SRAMs.
module tb_mp_cache_tag_lookup;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          resp_hit;
  logic [1:0]    resp_way;
  logic [1:0]    resp_victim_way;
  logic          resp_victim_valid;
  logic          resp_victim_dirty;
  logic [23:0]   resp_victim_tag;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [1:0]    upd_way = '0;
  logic [3:0]    upd_set = '0;
  logic [25:0]   upd_entry = '0;
  logic [3:0]    sram_csb;
  logic [3:0]    sram_web;
  logic [15:0]   sram_addr;
  logic [103:0]  sram_din;
  logic [103:0]  sram_dout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mp_cache_tag_lookup dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_hit          (resp_hit),
    .resp_way          (resp_way),
    .resp_victim_way   (resp_victim_way),
    .resp_victim_valid (resp_victim_valid),
    .resp_victim_dirty (resp_victim_dirty),
    .resp_victim_tag   (resp_victim_tag),
    .upd_valid         (upd_valid),
    .upd_ready         (upd_ready),
    .upd_way           (upd_way),
    .upd_set           (upd_set),
    .upd_entry         (upd_entry),
    .sram_csb          (sram_csb),
    .sram_web          (sram_web),
    .sram_addr         (sram_addr),
    .sram_din          (sram_din),
    .sram_dout         (sram_dout)
  );

  // Power-up contents are valid+dirty garbage so a missing clear shows up as a hit.
  logic [25:0] mem [4][16] = '{default: '{default: 26'h3ABCDE1}};
  logic [25:0] dout_r [4] = '{default: 26'h0};
  int          zero_wr [4] = '{default: 0};
  logic [15:0] zero_mask [4] = '{default: 16'h0};

  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (!sram_csb[w]) begin
        if (!sram_web[w]) begin
          mem[w][sram_addr[w*4 +: 4]] = sram_din[w*26 +: 26];
          if (sram_din[w*26 +: 26] == 26'h0) begin
            zero_wr[w] = zero_wr[w] + 1;
            zero_mask[w][sram_addr[w*4 +: 4]] = 1'b1;
          end
        end else begin
          dout_r[w] <= mem[w][sram_addr[w*4 +: 4]];
        end
      end
    end
  end

  assign sram_dout = {dout_r[3], dout_r[2], dout_r[1], dout_r[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the response.
  task automatic lookup(input string nm, input logic [31:0] addr, input logic eh, input logic [1:0] ew,
                        input logic [1:0] evw, input logic evv, input logic evd, input logic [23:0] evt);
    upd_valid = 1'b0;
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({nm, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({nm, ".hit"}, 32'(resp_hit), 32'(eh));
    chk({nm, ".way"}, 32'(resp_way), 32'(ew));
    chk({nm, ".victim_way"}, 32'(resp_victim_way), 32'(evw));
    chk({nm, ".victim_valid"}, 32'(resp_victim_valid), 32'(evv));
    chk({nm, ".victim_dirty"}, 32'(resp_victim_dirty), 32'(evd));
    chk({nm, ".victim_tag"}, 32'(resp_victim_tag), 32'(evt));
    $display("[TB] lookup %s addr=%h hit=%0d way=%0d victim=%0d v=%0d d=%0d tag=%h", nm, addr,
             resp_hit, resp_way, resp_victim_way, resp_victim_valid, resp_victim_dirty, resp_victim_tag);
    @(negedge clk);
  endtask

  task automatic upd(input logic [1:0] w, input logic [3:0] s, input logic [25:0] e);
    upd_valid = 1'b1;
    upd_way   = w;
    upd_set   = s;
    upd_entry = e;
    #1;
    chk("upd.upd_ready", 32'(upd_ready), 32'd1);
    $display("[TB] update way=%0d set=%0d entry=%h", w, s, e);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.upd_ready", 32'(upd_ready), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.csb", 32'(sram_csb), 32'hF);
    chk("rst.web", 32'(sram_web), 32'hF);
    chk("rst.addr", 32'(sram_addr), 32'h0);
    chk("rst.din_nonzero", 32'(|sram_din), 32'd0);

    // INIT: 16 cycles of clearing with req_valid held high.
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("init.req_ready", 32'(req_ready), 32'd0);
      chk("init.addr", 32'(sram_addr), 32'({4{4'(c)}}));
      chk("init.csb", 32'(sram_csb), 32'h0);
      @(negedge clk);
    end
    for (int w = 0; w < 4; w++) begin
      chk("init.zero_writes", 32'(zero_wr[w]), 32'd16);
      chk("init.zero_sets", 32'(zero_mask[w]), 32'hFFFF);
    end
    lookup("first", 32'h0000_0040, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 24'h0);

    // Read-after-update in the very next cycle.
    upd(2'd2, 4'd5, 26'h2ABCDE1);
    lookup("raw", 32'hABCDE150, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 24'h0);

    // Fill set 3, then walk the PLRU with hits on ways 0,2,1.
    upd(2'd0, 4'd3, 26'h2111111);
    upd(2'd1, 4'd3, 26'h3222222);
    upd(2'd2, 4'd3, 26'h2333333);
    upd(2'd3, 4'd3, 26'h3444444);
    lookup("hit0", 32'h11111130, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 24'h111111);
    lookup("hit2", 32'h33333330, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 24'h333333);
    lookup("hit1", 32'h22222230, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 24'h222222);
    lookup("plru_victim", 32'h55555530, 1'b0, 2'd0, 2'd3, 1'b1, 1'b1, 24'h444444);

    // Set 9 holds only way 0: lowest invalid way is the victim.
    upd(2'd0, 4'd9, 26'h2999999);
    lookup("empty9", 32'h12345690, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 24'h0);

    // Stall with both an update and a request waiting.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'hABCDE150;
    #1;
    chk("stall.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_addr  = 32'h77777750;
    upd_valid = 1'b1;
    upd_way   = 2'd1;
    upd_set   = 4'd5;
    upd_entry = 26'h2777777;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall.resp_valid", 32'(resp_valid), 32'd1);
      chk("stall.hit", 32'(resp_hit), 32'd1);
      chk("stall.way", 32'(resp_way), 32'd2);
      chk("stall.csb", 32'(sram_csb), 32'hF);
      chk("stall.upd_ready", 32'(upd_ready), 32'd0);
      chk("stall.req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    chk("release.upd_ready", 32'(upd_ready), 32'd1);
    chk("release.req_ready", 32'(req_ready), 32'd0);
    chk("release.csb", 32'(sram_csb), 32'hD);
    chk("release.web", 32'(sram_web), 32'hD);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    chk("release2.req_ready", 32'(req_ready), 32'd1);
    chk("release2.csb", 32'(sram_csb), 32'h0);
    chk("release2.web", 32'(sram_web), 32'hF);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("release3.resp_valid", 32'(resp_valid), 32'd1);
    chk("release3.hit", 32'(resp_hit), 32'd1);
    chk("release3.way", 32'(resp_way), 32'd1);
    chk("release3.victim_way", 32'(resp_victim_way), 32'd0);
    $display("[TB] lookup stalled-request addr=77777750 hit=%0d way=%0d", resp_hit, resp_way);
    @(negedge clk);

    // Reset while a response is pending.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'hABCDE150;
    #1;
    chk("prerst.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("prerst.resp_valid", 32'(resp_valid), 32'd1);
    chk("prerst.hit", 32'(resp_hit), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst.csb", 32'(sram_csb), 32'hF);
    @(negedge clk);
    rst        = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("reinit.req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    repeat (15) @(negedge clk);
    lookup("post_rst", 32'hABCDE150, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 24'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mp_cache_tag_lookup.md
Name: mp_cache_tag_lookup

Overview:
- Lookup/compare stage for a 4-way, 16-set cache with 16-byte lines.
- Drives port 0 of four 16x26 tag-array SRAM instances, one per way, and consumes their read data one cycle later.
- Produces hit/way plus victim information, and maintains per-set PLRU state.
- Sits between the CPU request path and the cache controller FSM; the controller writes tags back through the update port.

Parameters:
WAYS, 4, ways (fixed at 4; PLRU logic assumes it)
SETS, 16, sets; index width 4
TAG_W, 24, tag width; address split is tag[31:8], set[7:4], offset[3:0]

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  lookup request
req_ready  output  1  lookup accepted when req_valid && req_ready
req_addr  input  32  byte address
resp_valid  output  1  lookup result valid
resp_ready  input  1  consumer accepts result
resp_hit  output  1  tag match in a valid way
resp_way  output  2  hit way (0 on miss)
resp_victim_way  output  2  replacement way for the set
resp_victim_valid  output  1  victim entry valid
resp_victim_dirty  output  1  victim entry dirty
resp_victim_tag  output  24  victim tag (for writeback address)
upd_valid  input  1  tag write request
upd_ready  output  1  write accepted when upd_valid && upd_ready
upd_way  input  2  way to write
upd_set  input  4  set to write
upd_entry  input  26  {valid, dirty, tag[23:0]}
sram_csb  output  4  per-way active-low chip select
sram_web  output  4  per-way active-low write enable
sram_addr  output  4x4  per-way address (packed)
sram_din  output  4x26  per-way write data (packed)
sram_dout  input  4x26  per-way read data

Behaviour:
- Entry format: bit25 valid, bit24 dirty, bits23:0 tag.
- SRAM timing: the SRAM registers csb/web/addr/din on the edge. Read data is valid the cycle after issue and holds while csb stays high. A write commits one edge after issue. The SRAM re-commits the same write on later edges until a read is issued; this is idempotent and acceptable.
- Reset: state=INIT, init_cnt=0, PLRU all 0, resp_valid=0, req_ready=0, upd_ready=0, sram_csb=4'hF, sram_web=4'hF, sram_addr/sram_din=0.
- INIT: each cycle writes 26'h0 to set init_cnt in all 4 ways. init_cnt increments; after set 15 the state goes to RUN, so INIT lasts 16 cycles. Ready signals stay low throughout.
- RUN:
  - `free = !s1_valid || resp_ready`.
  - `upd_ready = free`.
  - `req_ready = free && !upd_valid`, so an update has priority over a lookup.
- Update fire: that way only gets csb=0, web=0, addr=upd_set, din=upd_entry. If bit25 is set, PLRU[upd_set] is touched with upd_way.
- Request fire: all 4 ways get csb=0, web=1, addr=req_addr[7:4]. Next cycle s1_valid=1 and the tag and set are held in s1 registers.
- resp_valid = s1_valid, and the response is computed combinationally from sram_dout.
  - hit_w = dout[w][25] && dout[w][23:0]==s1_tag.
  - Multi-way hit is illegal; flag it with an assertion and report the lowest index.
- Victim selection:
  - If any way is invalid, pick the lowest-index invalid way.
  - Otherwise use PLRU bits b[2:0]: b0==0 selects way b1?1:0; b0==1 selects way b2?3:2.
- Touch way w: b0 = (w<2); if w<2 then b1 = (w==0), else b2 = (w==2).
- resp fire with hit touches PLRU[s1_set] with resp_way. If an update touches the same set in the same cycle, the update's touch is applied last.
- Stall: while resp_valid && !resp_ready, csb stays high on all ways. Outputs stay stable (SRAM holds data), and no update or request is accepted.
- Back-to-back: on resp fire, a new request or update may issue in the same cycle. Throughput is 1 lookup/cycle.
- Read-after-update to the same set returns the new entry: a lookup issued the cycle after an update sees the written data.
- Reset mid-operation drops the pending response and re-runs INIT.

Decomposition:
- Package mp_cache_pkg: SETS/WAYS/TAG_W constants, entry bit positions (VALID_BIT=25, DIRTY_BIT=24), tag_entry_t struct, addr-field slice functions.
- One sub-module, mp_cache_plru4: 16x3-bit PLRU storage with touch and victim logic, including the same-set dual-touch ordering rule.

Test Plan:
- Reset, then hold req_valid=1 -> req_ready=0 for 16 cycles. Each way sees 16 writes of 0 to sets 0..15. First acceptance on cycle 17.
- Update way2 set5 = {1,0,24'hABCDE1}, then lookup 0xABCDE150 next cycle -> resp_hit=1, resp_way=2.
- Fill all 4 ways of set 3 with valid tags, then hit ways 0,2,1 -> miss lookup gives resp_victim_way=3 with its tag and dirty bit.
- Set 9 empty except way0 -> miss gives resp_victim_way=1, resp_victim_valid=0.
- Response with resp_ready=0 for 5 cycles while upd_valid=1 and req_valid=1 -> outputs stable, no SRAM csb low, upd_ready=0. Release -> update issues first, then the request.
- Assert rst during a pending response -> resp_valid=0 immediately, INIT repeats, and a prior hit now misses.
